// File: rtl/scr1_tcm_portb_arb_if.sv
// Requester-side bus for the TCM port B arbiter: request/ack handshake plus one-cycle response.
interface scr1_tcm_portb_arb_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WIDTH  = 32
);
    logic              req;
    logic              we;
    logic [1:0]        width;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              ack;
    logic              resp_vld;
    logic              resp_err;
    logic [WIDTH-1:0]  rdata;

    modport master (
        output req, we, width, addr, wdata,
        input  ack, resp_vld, resp_err, rdata
    );

    modport slave (
        input  req, we, width, addr, wdata,
        output ack, resp_vld, resp_err, rdata
    );
endinterface

// File: rtl/scr1_tcm_portb_arb.sv
// Core/DMA arbiter for TCM port B: grants one access per cycle, drives the memory port,
// and returns aligned read data to the winner one cycle later.
module scr1_tcm_portb_arb #(
    parameter int unsigned SCR1_WIDTH   = 32,
    parameter int unsigned SCR1_ADDR_W  = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    scr1_tcm_portb_arb_if.slave     io_core,
    scr1_tcm_portb_arb_if.slave     io_dma,
    output logic                    o_renb,
    output logic                    o_wenb,
    output logic [3:0]              o_webb,
    output logic [SCR1_ADDR_W-3:0]  o_addrb,
    output logic [SCR1_WIDTH-1:0]   o_datab,
    input  logic [SCR1_WIDTH-1:0]   i_qb
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]             r_starve_cnt;
    logic                   r_resp_vld;
    logic                   r_resp_own;
    logic                   r_resp_rd;
    logic                   r_resp_err;
    logic [1:0]             r_resp_off;
    logic [1:0]             r_resp_width;

    logic                   w_c_req;
    logic                   w_d_req;
    logic                   w_grant_c;
    logic                   w_grant_d;
    logic                   w_grant;
    logic                   w_we;
    logic [1:0]             w_width;
    logic [SCR1_ADDR_W-1:0] w_addr;
    logic [SCR1_WIDTH-1:0]  w_wdata;
    logic                   w_err;
    logic [3:0]             w_strb;
    logic [SCR1_WIDTH-1:0]  w_repl;
    logic [3:0]             w_starve_nxt;
    logic [SCR1_WIDTH-1:0]  w_shift;
    logic [SCR1_WIDTH-1:0]  w_mask;
    logic [SCR1_WIDTH-1:0]  w_rdata;
    logic                   w_vld;

    // Core has priority; a DMA request that has waited STARVE_LIMIT core grants takes the port.
    assign w_c_req   = ~rst & io_core.req;
    assign w_d_req   = ~rst & io_dma.req;
    assign w_grant_d = w_d_req & (~w_c_req | (r_starve_cnt == LIMIT));
    assign w_grant_c = w_c_req & ~w_grant_d;
    assign w_grant   = w_grant_c | w_grant_d;

    assign io_core.ack = w_grant_c;
    assign io_dma.ack  = w_grant_d;

    assign w_we    = w_grant_d ? io_dma.we    : io_core.we;
    assign w_width = w_grant_d ? io_dma.width : io_core.width;
    assign w_addr  = w_grant_d ? io_dma.addr  : io_core.addr;
    assign w_wdata = w_grant_d ? io_dma.wdata : io_core.wdata;

    always_comb begin
        w_err  = 1'b1;
        w_strb = 4'b0000;
        w_repl = w_wdata;
        case (w_width)
            2'b00: begin
                w_err  = 1'b0;
                w_strb = 4'b0001 << w_addr[1:0];
                w_repl = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_err  = w_addr[0];
                w_strb = w_addr[1] ? 4'b1100 : 4'b0011;
                w_repl = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_err  = |w_addr[1:0];
                w_strb = 4'b1111;
                w_repl = w_wdata;
            end
            default: begin
                w_err  = 1'b1;
                w_strb = 4'b0000;
                w_repl = w_wdata;
            end
        endcase
    end

    always_comb begin
        o_renb  = w_grant & ~w_err & ~w_we;
        o_wenb  = w_grant & ~w_err & w_we;
        o_webb  = o_wenb ? w_strb : 4'b0000;
        o_datab = o_wenb ? w_repl : '0;
        o_addrb = w_grant ? w_addr[SCR1_ADDR_W-1:2] : '0;
    end

    always_comb begin
        w_starve_nxt = 4'd0;
        if (w_grant_c && io_dma.req) begin
            w_starve_nxt = (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
            r_resp_vld   <= 1'b0;
            r_resp_own   <= 1'b0;
            r_resp_rd    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_off   <= 2'b00;
            r_resp_width <= 2'b00;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_resp_vld   <= w_grant;
            if (w_grant) begin
                r_resp_own   <= w_grant_d;
                r_resp_rd    <= ~w_we;
                r_resp_err   <= w_err;
                r_resp_off   <= w_addr[1:0];
                r_resp_width <= w_width;
            end
        end
    end

    assign w_shift = i_qb >> {r_resp_off, 3'b000};

    always_comb begin
        case (r_resp_width)
            2'b00:   w_mask = 32'h0000_00FF;
            2'b01:   w_mask = 32'h0000_FFFF;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
    end

    // A response landing while rst is high is dropped.
    assign w_vld   = r_resp_vld & ~rst;
    assign w_rdata = (r_resp_rd & ~r_resp_err) ? (w_shift & w_mask) : '0;

    assign io_core.resp_vld = w_vld & ~r_resp_own;
    assign io_core.resp_err = w_vld & ~r_resp_own & r_resp_err;
    assign io_core.rdata    = (w_vld & ~r_resp_own) ? w_rdata : '0;

    assign io_dma.resp_vld  = w_vld & r_resp_own;
    assign io_dma.resp_err  = w_vld & r_resp_own & r_resp_err;
    assign io_dma.rdata     = (w_vld & r_resp_own) ? w_rdata : '0;

endmodule

// File: tb/tb_scr1_tcm_portb_arb.sv
// Directed bench for scr1_tcm_portb_arb: per-cycle bus checks plus a response scoreboard.
module tb_scr1_tcm_portb_arb;

    typedef struct packed {
        logic        own;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        renb;
    logic        wenb;
    logic [3:0]  webb;
    logic [13:0] addrb;
    logic [31:0] datab;
    logic [31:0] qb;
    logic [31:0] mem [0:255];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    scr1_tcm_portb_arb_if #(.ADDR_W(16), .WIDTH(32)) core_bus ();
    scr1_tcm_portb_arb_if #(.ADDR_W(16), .WIDTH(32)) dma_bus ();

    scr1_tcm_portb_arb #(
        .SCR1_WIDTH   (32),
        .SCR1_ADDR_W  (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_core (core_bus),
        .io_dma  (dma_bus),
        .o_renb  (renb),
        .o_wenb  (wenb),
        .o_webb  (webb),
        .o_addrb (addrb),
        .o_datab (datab),
        .i_qb    (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (renb === 1'b1) qb <= mem[addrb[7:0]];
        if (wenb === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (webb[i]) mem[addrb[7:0]][8*i +: 8] <= datab[8*i +: 8];
            end
        end
    end

    // Response monitor: every valid response must match the oldest expectation.
    always @(negedge clk) begin
        logic [66:0] act;
        logic [66:0] req;
        if (core_bus.resp_vld === 1'b1 || dma_bus.resp_vld === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: c_vld=%b d_vld=%b, required no response",
                         core_bus.resp_vld, dma_bus.resp_vld);
            end else begin
                mon_e = exp_q.pop_front();
                act = {core_bus.resp_vld, dma_bus.resp_vld,
                       mon_e.own ? dma_bus.resp_err : core_bus.resp_err,
                       core_bus.rdata, dma_bus.rdata};
                req = {~mon_e.own, mon_e.own, mon_e.err,
                       mon_e.own ? 32'h0 : mon_e.rdata, mon_e.own ? mon_e.rdata : 32'h0};
                if (act !== req) begin
                    n_fail++;
                    $display("FAIL resp: got vld c/d=%b%b err=%b c_rdata=%h d_rdata=%h, required %b%b err=%b c_rdata=%h d_rdata=%h",
                             act[66], act[65], act[64], act[63:32], act[31:0],
                             req[66], req[65], req[64], req[63:32], req[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_c(input logic req, input logic we, input logic [1:0] width,
                         input logic [15:0] addr, input logic [31:0] wdata);
        core_bus.req   = req;
        core_bus.we    = we;
        core_bus.width = width;
        core_bus.addr  = addr;
        core_bus.wdata = wdata;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [1:0] width,
                         input logic [15:0] addr, input logic [31:0] wdata);
        dma_bus.req   = req;
        dma_bus.we    = we;
        dma_bus.width = width;
        dma_bus.addr  = addr;
        dma_bus.wdata = wdata;
    endtask

    task automatic push(input logic own, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.own   = own;
        e.err   = err;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Check same-cycle grant/memory drive at the falling edge, then advance one cycle.
    task automatic step(input string name, input logic ca, input logic da, input logic rn,
                        input logic wn, input logic [3:0] wb, input logic [13:0] ab,
                        input logic [31:0] db, input bit chk_db, input bit chk_rz);
        logic [53:0] act;
        logic [53:0] req;
        logic [67:0] ract;
        @(negedge clk);
        act = {core_bus.ack, dma_bus.ack, renb, wenb, webb, addrb, chk_db ? datab : 32'h0};
        req = {ca, da, rn, wn, wb, ab, chk_db ? db : 32'h0};
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got ack c/d=%b%b renb=%b wenb=%b webb=%b addrb=%h datab=%h, required %b%b renb=%b wenb=%b webb=%b addrb=%h datab=%h",
                     name, act[53], act[52], act[51], act[50], act[49:46], act[45:32], act[31:0],
                     req[53], req[52], req[51], req[50], req[49:46], req[45:32], req[31:0]);
        end
        if (chk_rz) begin
            ract = {core_bus.resp_vld, dma_bus.resp_vld, core_bus.resp_err, dma_bus.resp_err,
                    core_bus.rdata, dma_bus.rdata};
            n_tests++;
            if (ract !== 68'h0) begin
                n_fail++;
                $display("FAIL %s_resp_zero: got vld=%b%b err=%b%b c_rdata=%h d_rdata=%h, required all zero",
                         name, ract[67], ract[66], ract[65], ract[64], ract[63:32], ract[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit dw;
        rst = 1'b1;
        set_c(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
        set_d(1'b1, 1'b0, 2'b10, 16'h0000, 32'h0);
        step("rst_hold0", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
        step("rst_hold1", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 1);
        rst = 1'b0;
        set_c(1'b0, 1'b1, 2'b10, 16'h1234, 32'hFFFF_FFFF);
        set_d(1'b0, 1'b1, 2'b10, 16'h0044, 32'h5555_5555);
        step("post_rst_idle", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 1);

        set_d(1'b1, 1'b1, 2'b10, 16'h0010, 32'hDEAD_BEEF); push(1, 0, 32'h0);
        step("d_wr_word4", 0, 1, 0, 1, 4'hF, 14'h4, 32'hDEAD_BEEF, 1, 0);
        set_d(1'b1, 1'b1, 2'b10, 16'h0000, 32'h1234_5678); push(1, 0, 32'h0);
        step("d_wr_word0", 0, 1, 0, 1, 4'hF, 14'h0, 32'h1234_5678, 1, 0);
        set_d(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);

        set_c(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0); push(0, 0, 32'hDEAD_BEEF);
        step("c_rd_word", 1, 0, 1, 0, 4'h0, 14'h4, 32'h0, 1, 0);
        set_c(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);

        set_d(1'b1, 1'b1, 2'b00, 16'h0007, 32'h0000_00A5); push(1, 0, 32'h0);
        step("d_wr_byte", 0, 1, 0, 1, 4'b1000, 14'h1, 32'hA5A5_A5A5, 1, 0);
        set_d(1'b1, 1'b0, 2'b00, 16'h0007, 32'h0); push(1, 0, 32'h0000_00A5);
        step("d_rd_byte", 0, 1, 1, 0, 4'h0, 14'h1, 32'h0, 1, 0);
        set_d(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);

        set_c(1'b1, 1'b1, 2'b01, 16'h0003, 32'h0000_BEEF); push(0, 1, 32'h0);
        step("c_wr_half_misal", 1, 0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 0);
        set_c(1'b1, 1'b0, 2'b01, 16'h0002, 32'h0); push(0, 0, 32'h0000_1234);
        step("c_rd_half_hi", 1, 0, 1, 0, 4'h0, 14'h0, 32'h0, 1, 0);
        set_c(1'b1, 1'b0, 2'b00, 16'h0011, 32'h0); push(0, 0, 32'h0000_00BE);
        step("c_rd_byte1", 1, 0, 1, 0, 4'h0, 14'h4, 32'h0, 1, 0);
        set_c(1'b1, 1'b0, 2'b11, 16'h0010, 32'h0); push(0, 1, 32'h0);
        step("c_rd_width11", 1, 0, 0, 0, 4'h0, 14'h4, 32'h0, 0, 0);
        set_c(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);
        set_d(1'b1, 1'b0, 2'b10, 16'h0012, 32'h0); push(1, 1, 32'h0);
        step("d_rd_word_misal", 0, 1, 0, 0, 4'h0, 14'h4, 32'h0, 0, 0);
        set_d(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);

        set_c(1'b1, 1'b1, 2'b10, 16'h0020, 32'h1122_3344); push(0, 0, 32'h0);
        step("c_wr_word8", 1, 0, 0, 1, 4'hF, 14'h8, 32'h1122_3344, 1, 0);
        set_c(1'b1, 1'b1, 2'b01, 16'h0022, 32'h0000_CAFE); push(0, 0, 32'h0);
        step("c_wr_half_hi", 1, 0, 0, 1, 4'b1100, 14'h8, 32'hCAFE_CAFE, 1, 0);
        set_c(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);
        set_d(1'b1, 1'b1, 2'b00, 16'h0021, 32'h0000_0077); push(1, 0, 32'h0);
        step("d_wr_byte1", 0, 1, 0, 1, 4'b0010, 14'h8, 32'h7777_7777, 1, 0);
        set_d(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);
        set_c(1'b1, 1'b0, 2'b10, 16'h0020, 32'h0); push(0, 0, 32'hCAFE_7744);
        step("c_rd_word8", 1, 0, 1, 0, 4'h0, 14'h8, 32'h0, 1, 0);

        set_c(1'b0, 1'b1, 2'b10, 16'h00F0, 32'hAAAA_AAAA);
        set_d(1'b0, 1'b1, 2'b10, 16'h00F4, 32'hBBBB_BBBB);
        step("idle", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 0);

        // Both held: C,C,C,C,D,C,C,C,C,D then four more core grants before a mid-run reset.
        for (int k = 1; k <= 14; k++) begin
            dw = (k == 5) || (k == 10);
            set_c(1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
            set_d(1'b1, 1'b0, 2'b10, 16'h0000, 32'h0);
            if (k < 14) push(dw, 0, dw ? 32'h1234_5678 : 32'hDEAD_BEEF);
            step($sformatf("starve_%0d", k), !dw, dw, 1, 0, 4'h0, dw ? 14'h0 : 14'h4,
                 32'h0, 1, 0);
        end
        rst = 1'b1;
        step("mid_rst", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 1);
        rst = 1'b0;
        push(0, 0, 32'hDEAD_BEEF);
        step("post_mid_rst", 1, 0, 1, 0, 4'h0, 14'h4, 32'h0, 1, 1);
        set_c(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);
        set_d(1'b0, 1'b0, 2'b00, 16'h0000, 32'h0);
        step("tail_idle0", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 0);
        step("tail_idle1", 0, 0, 0, 0, 4'h0, 14'h0, 32'h0, 1, 1);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL resp_missing: got %0d outstanding responses, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_tcm_portb_arb.md
# scr1_tcm_portb_arb

Two-requester arbiter and access sequencer for port B of the TCM dual-port memory. It shares the single read/write port between the core data interface and the DMA/loader interface. For each granted request it generates the word address, byte-write strobes and lane-replicated write data. It returns right-justified read data to the winning requester one cycle later. Port A (instruction fetch) is not touched by this block.

## Interface
- SCR1_WIDTH, 32: data width; only 32 is supported (4 byte lanes).
- SCR1_ADDR_W, 16: byte-address width; memory word address is [SCR1_ADDR_W-1:2].
- STARVE_LIMIT, 4: consecutive core grants after which a waiting DMA request wins; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core request valid; held stable until c_ack.
- c_we  in  1  1 = write, 0 = read.
- c_width  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
- c_addr  in  SCR1_ADDR_W  byte address.
- c_wdata  in  32  write data, right-justified.
- c_ack  out  1  request accepted this cycle (combinational).
- c_resp_vld  out  1  one-cycle response strobe.
- c_resp_err  out  1  response is an error (misaligned or illegal width).
- c_rdata  out  32  read data, right-justified, zero-extended.
- d_req, d_we, d_width, d_addr, d_wdata, d_ack, d_resp_vld, d_resp_err, d_rdata: DMA port, identical semantics.
- renb  out  1  memory read enable.
- wenb  out  1  memory write enable.
- webb  out  4  memory byte-write strobes.
- addrb  out  SCR1_ADDR_W-2  memory word address.
- datab  out  32  memory write data.
- qb  in  32  memory read data, valid the cycle after renb.

## Operation
- Grant (combinational, per cycle)
  - While rst=1, no grant.
  - Otherwise, if exactly one requester has req=1, it wins.
  - If both are requesting, the core wins unless starve_cnt == STARVE_LIMIT, in which case the DMA wins.
- Acknowledge and memory drive
  - The winner's ack=1 in the same cycle.
  - The winner drives addrb = addr[SCR1_ADDR_W-1:2].
  - A read drives renb=1, wenb=0, webb=0.
  - A write drives wenb=1, renb=0, with byte strobes:
    - byte: webb = 1 << addr[1:0]
    - halfword: webb = 4'b0011 << (2*addr[1])
    - word: webb = 4'hF
  - Write data is replicated across lanes: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- Error requests
  - Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0) and width 11 are acked.
  - They cause no memory activity: renb=wenb=0, webb=0.
  - They still produce a response with err=1 and rdata=0.
- Idle drive: with no grant, renb=wenb=0, webb=0, and addrb/datab=0.
- Starvation counter (starve_cnt, 4 bits, reset 0)
  - Increments when the core is granted while d_req=1.
  - Clears when the DMA is granted or d_req=0.
  - Saturates at STARVE_LIMIT.
- Response pipeline registers, captured on every grant:
  - resp_own (0 core, 1 DMA)
  - resp_rd
  - resp_err
  - resp_off = addr[1:0]
  - resp_width
  - resp_vld (set to 1 on a grant, else 0)
- Response outputs (cycle after grant)
  - Owner's resp_vld=1; the other owner's resp_vld=0.
  - resp_err = registered err.
  - rdata = (qb >> 8*resp_off) masked to width (byte 0x000000FF, half 0x0000FFFF, word all ones) when resp_rd && !resp_err, else 0.
  - Writes respond with err=0 and rdata=0.
  - Non-owner rdata=0.

## Timing
- Reset values
  - All registered state is 0.
  - In the cycle after rst deasserts: c/d_resp_vld=0, c/d_resp_err=0, c/d_rdata=0.
  - During rst: acks=0, renb=wenb=0, webb=0.
- Latency
  - Request-to-ack: 0 cycles.
  - Ack-to-response: exactly 1 cycle.
  - One grant per cycle; back-to-back grants to either requester are allowed with no bubble.
- A requester may raise a new req in its response cycle.
- A request not acked stays pending with no timeout.
- Reset mid-operation: a response due in the cycle after rst=1 is dropped (resp_vld=0), and the counter clears.
- Simultaneous read/write to the same word across consecutive cycles: the read returns memory contents as of the read edge. Write-before-read ordering is by grant order.

## Test plan
- Core read word: c_req, c_addr=0x0010, c_width=10, with memory word 4 = 0xDEADBEEF.
  - Same cycle: c_ack=1, renb=1, addrb=4.
  - Next cycle: c_resp_vld=1, c_rdata=0xDEADBEEF.
- Byte write then read: d write byte addr=0x0007, wdata=0xA5, then d read byte addr=0x0007.
  - Write cycle: webb=4'b1000, datab=0xA5A5A5A5.
  - Read response: d_rdata=0x000000A5.
- Misaligned: c write half at addr=0x0003.
  - c_ack=1, wenb=0.
  - Next cycle: c_resp_vld=1, c_resp_err=1, c_rdata=0.
- Starvation: c_req and d_req held high continuously, STARVE_LIMIT=4.
  - Grants: C,C,C,C,D,C,C,C,C,D…
  - d_ack at cycles 5 and 10.
- Halfword read upper: memory word = 0x12345678, c read half addr=0x0002.
  - c_rdata=0x00001234.
- Reset mid-operation: rst=1 in the cycle after a core read grant.
  - c_resp_vld=0 in the cycle after rst.
  - starve_cnt=0.
  - First post-reset grant behaves normally.
